// File: rtl/lane_power_pkg.sv
// Shared widths and saturation helpers for the lane power pipeline.
package lane_power_pkg;

    localparam int MAXW = 128;

    typedef logic [MAXW-1:0] wide_t;

    typedef struct packed {
        logic valid;
        logic last;
    } beat_ctl_t;

    function automatic int sum_width(input int lane_width, input int lanes);
        return 2 * lane_width + $clog2(lanes);
    endfunction

    function automatic logic sat_flag(input wide_t v, input int ow);
        return (v >> ow) != '0;
    endfunction

    function automatic wide_t sat_val(input wide_t v, input int ow);
        wide_t lim;
        lim = (wide_t'(1) << ow) - wide_t'(1);
        return sat_flag(v, ow) ? lim : v;
    endfunction

endpackage

// File: rtl/lane_power_sum_lane_square.sv
// Registered signed square of one lane.
module lane_square #(
    parameter int LANE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANE_WIDTH-1:0]   lane,
    output logic [2*LANE_WIDTH-1:0] sq
);

    logic signed [2*LANE_WIDTH-1:0] lane_x;
    logic signed [2*LANE_WIDTH-1:0] prod;

    // The true square fits in 2*LANE_WIDTH-1 bits, so the truncated product is exact.
    assign lane_x = {{LANE_WIDTH{lane[LANE_WIDTH-1]}}, lane};
    assign prod   = lane_x * lane_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq <= '0;
        end else if (en) begin
            sq <= prod;
        end
    end

endmodule

// File: rtl/lane_power_sum.sv
// Sum of squared signed lanes per beat or per packet, saturated to OUT_WIDTH.
module lane_power_sum
    import lane_power_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int LANE_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int ACCUM      = 0
) (
    input  logic                        s00_axis_aclk,
    input  logic                        s00_axis_areset,
    input  logic                        s00_axis_tvalid,
    input  logic                        s00_axis_tlast,
    input  logic [LANES*LANE_WIDTH-1:0] s00_axis_tdata,
    output logic                        s00_axis_tready,
    input  logic                        m00_axis_tready,
    output logic                        m00_axis_tvalid,
    output logic                        m00_axis_tlast,
    output logic [OUT_WIDTH-1:0]        m00_axis_tdata,
    output logic [OUT_WIDTH/8-1:0]      m00_axis_tstrb,
    output logic                        m00_axis_tuser
);

    localparam int SW = sum_width(LANE_WIDTH, LANES);
    localparam int AW = OUT_WIDTH + 1;

    logic                    enable;
    logic [2*LANE_WIDTH-1:0] sq [LANES];
    beat_ctl_t               s1;
    beat_ctl_t               s2;
    logic [SW-1:0]           lane_sum;
    logic [SW-1:0]           sum2;
    logic [AW-1:0]           acc;
    logic                    ovf;
    wide_t                   total;
    logic                    out_valid_d;
    logic                    out_last_d;
    logic                    out_user_d;
    logic [OUT_WIDTH-1:0]    out_data_d;

    assign enable          = !m00_axis_tvalid || m00_axis_tready;
    assign s00_axis_tready = enable;
    assign m00_axis_tstrb  = {(OUT_WIDTH/8){m00_axis_tvalid}};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_square #(
            .LANE_WIDTH(LANE_WIDTH)
        ) u_sq (
            .clk  (s00_axis_aclk),
            .rst  (s00_axis_areset),
            .en   (enable),
            .lane (s00_axis_tdata[k*LANE_WIDTH +: LANE_WIDTH]),
            .sq   (sq[k])
        );
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            s1 <= '0;
        end else if (enable) begin
            s1.valid <= s00_axis_tvalid;
            s1.last  <= s00_axis_tlast;
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + SW'(sq[k]);
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            s2   <= '0;
            sum2 <= '0;
        end else if (enable) begin
            s2   <= s1;
            sum2 <= lane_sum;
        end
    end

    always_comb begin
        total = wide_t'(sum2);
        if (ACCUM != 0) begin
            total = wide_t'(sum2) + wide_t'(acc);
        end
    end

    always_comb begin
        out_valid_d = s2.valid && ((ACCUM == 0) || s2.last);
        out_last_d  = s2.last;
        out_user_d  = sat_flag(total, OUT_WIDTH) || ((ACCUM != 0) && ovf);
        out_data_d  = OUT_WIDTH'(sat_val(total, OUT_WIDTH));
        if (out_user_d) begin
            out_data_d = '1;
        end
    end

    // A packet's tlast beat clears the accumulator in the same edge it emits.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (enable && s2.valid && (ACCUM != 0)) begin
            if (s2.last) begin
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= sat_flag(total, AW) ? '1 : AW'(total);
                ovf <= ovf || sat_flag(total, OUT_WIDTH);
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (enable) begin
            m00_axis_tvalid <= out_valid_d;
            m00_axis_tlast  <= out_valid_d && out_last_d;
            m00_axis_tuser  <= out_valid_d && out_user_d;
            m00_axis_tdata  <= out_valid_d ? out_data_d : '0;
        end
    end

endmodule

// File: tb/tb_lane_power_sum.sv
// Directed checks of lane_power_sum in per-beat, narrow-output and packet modes.
module tb_lane_power_sum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        m_tready = 1'b1;

    logic        a_s_tready, a_tvalid, a_tlast, a_tuser;
    logic [31:0] a_tdata;
    logic [3:0]  a_tstrb;
    logic        n_s_tready, n_tvalid, n_tlast, n_tuser;
    logic [23:0] n_tdata;
    logic [2:0]  n_tstrb;
    logic        c_s_tready, c_tvalid, c_tlast, c_tuser;
    logic [31:0] c_tdata;
    logic [3:0]  c_tstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lane_power_sum u_dut_a (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tready (a_s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (a_tvalid),
        .m00_axis_tlast  (a_tlast),
        .m00_axis_tdata  (a_tdata),
        .m00_axis_tstrb  (a_tstrb),
        .m00_axis_tuser  (a_tuser)
    );

    lane_power_sum #(.OUT_WIDTH(24)) u_dut_n (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tready (n_s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (n_tvalid),
        .m00_axis_tlast  (n_tlast),
        .m00_axis_tdata  (n_tdata),
        .m00_axis_tstrb  (n_tstrb),
        .m00_axis_tuser  (n_tuser)
    );

    lane_power_sum #(.ACCUM(1)) u_dut_c (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tready (c_s_tready),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (c_tvalid),
        .m00_axis_tlast  (c_tlast),
        .m00_axis_tdata  (c_tdata),
        .m00_axis_tstrb  (c_tstrb),
        .m00_axis_tuser  (c_tuser)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] bp_in  [8] = '{32'h0001_0002, 32'h0003_0004, 32'hFFFF_0000,
                                32'h000A_FFF6, 32'h0100_0000, 32'h7FFF_0000,
                                32'h0000_0006, 32'hFFFE_FFFD};
    logic [31:0] bp_exp [8] = '{32'd5, 32'd25, 32'd1, 32'd200, 32'd65536,
                                32'h3FFF_0001, 32'd36, 32'd13};

    int          idx, ocnt, nout;
    logic        hold;
    logic [31:0] held;
    logic [31:0] got_d [4];
    logic        got_l [4];

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_tvalid", a_tvalid, 0);
        chk("rst_tdata", a_tdata, 0);
        chk("rst_tstrb", a_tstrb, 0);
        chk("rst_tuser", a_tuser, 0);
        chk("rst_acc_tvalid", c_tvalid, 0);
        chk("rst_s_tready", a_s_tready, 1);
        rst = 1'b0;
        m_tready = 1'b1;

        // lanes -4 and +3, latency and tlast passthrough
        beat(32'h0003_FFFC, 1'b1);
        @(negedge clk);
        chk("lat_early", a_tvalid, 0);
        @(negedge clk);
        chk("sq_valid", a_tvalid, 1);
        chk("sq_data", a_tdata, 25);
        chk("sq_user", a_tuser, 0);
        chk("sq_last", a_tlast, 1);
        chk("sq_strb", a_tstrb, 4'hF);
        @(negedge clk);
        chk("bubble", a_tvalid, 0);

        // most-negative lanes, wide and narrow output
        beat(32'h8000_8000, 1'b0);
        repeat (2) @(negedge clk);
        chk("neg_data", a_tdata, 32'h8000_0000);
        chk("neg_user", a_tuser, 0);
        chk("neg_last", a_tlast, 0);
        chk("sat_valid", n_tvalid, 1);
        chk("sat_data", n_tdata, 24'hFF_FFFF);
        chk("sat_user", n_tuser, 1);
        chk("sat_strb", n_tstrb, 3'b111);

        // backpressure stream on the per-beat instance
        do_reset();
        idx = 0;
        ocnt = 0;
        hold = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 400 && ocnt < 8; cyc++) begin
            @(negedge clk);
            m_tready = 1'($urandom_range(0, 1));
            s_tvalid = (idx < 8);
            s_tdata  = (idx < 8) ? bp_in[idx] : '0;
            s_tlast  = (idx == 7);
            #1;
            if (hold) begin
                chk("bp_hold_valid", a_tvalid, 1);
                chk("bp_hold_data", a_tdata, held);
            end
            if (a_tvalid && m_tready) begin
                chk("bp_data", a_tdata, bp_exp[ocnt]);
                chk("bp_last", a_tlast, (ocnt == 7));
                ocnt++;
            end
            hold = a_tvalid && !m_tready;
            held = a_tdata;
            if (s_tvalid && a_s_tready) idx++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("bp_count", ocnt, 8);
        m_tready = 1'b1;
        nout = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_tvalid) nout++;
        end
        chk("bp_no_dup", nout, 0);

        // packet accumulation: 4 x (1,1) then 1 x (2,0)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = (i < 4) ? 32'h0001_0001 : 32'h0000_0002;
            s_tlast  = (i >= 3);
        end
        nout = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            if (c_tvalid) begin
                if (nout < 4) begin
                    got_d[nout] = c_tdata;
                    got_l[nout] = c_tlast;
                end
                nout++;
            end
        end
        chk("acc_count", nout, 2);
        chk("acc_p1_data", got_d[0], 8);
        chk("acc_p1_last", got_l[0], 1);
        chk("acc_p2_data", got_d[1], 4);
        chk("acc_p2_last", got_l[1], 1);

        // reset mid-packet and mid-stall
        do_reset();
        m_tready = 1'b0;
        beat(32'h0001_0001, 1'b0);
        beat(32'h0001_0001, 1'b0);
        chk("stall_valid", a_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", a_tvalid, 0);
        chk("rst_async_data", a_tdata, 0);
        chk("rst_async_strb", a_tstrb, 0);
        chk("rst_acc_valid", c_tvalid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_valid", c_tvalid, 0);
        end
        rst = 1'b0;
        m_tready = 1'b1;
        beat(32'h0000_0003, 1'b1);
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (c_tvalid) begin
                if (nout < 4) begin
                    got_d[nout] = c_tdata;
                    got_l[nout] = c_tlast;
                end
                nout++;
            end
        end
        chk("post_rst_count", nout, 1);
        chk("post_rst_data", got_d[0], 9);
        chk("post_rst_last", got_l[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_power_sum.md
LANE_POWER_SUM -- requirements
Module: lane_power_sum

Interface
REQ-001 SHALL have parameter LANES, default 2, number of signed lanes packed in each input beat.
REQ-002 SHALL have parameter LANE_WIDTH, default 16, bits per signed lane.
REQ-003 SHALL have parameter OUT_WIDTH, default 32, width of the unsigned result.
REQ-004 SHALL have parameter ACCUM, default 0: 0 = one result per input beat; 1 = one result per packet, summed over all beats up to and including tlast.
REQ-005 SHALL have port s00_axis_aclk, input, 1, the single clock for all logic.
REQ-006 SHALL have port s00_axis_areset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports s00_axis_tvalid, input, 1; s00_axis_tlast, input, 1; s00_axis_tdata, input, LANES*LANE_WIDTH, with lane k at bits [k*LANE_WIDTH +: LANE_WIDTH]; s00_axis_tready, output, 1.
REQ-008 SHALL have ports m00_axis_tready, input, 1; m00_axis_tvalid, output, 1; m00_axis_tlast, output, 1; m00_axis_tdata, output, OUT_WIDTH; m00_axis_tstrb, output, OUT_WIDTH/8; m00_axis_tuser, output, 1, the saturation flag.

Function
REQ-009 SHALL compute, per accepted beat, the sum over k of lane_k*lane_k, with each lane treated as two's-complement signed.
REQ-010 SHALL size internal squares at 2*LANE_WIDTH bits and the lane sum at 2*LANE_WIDTH+clog2(LANES) bits, so no intermediate overflow is possible.
REQ-011 SHALL, when the final value exceeds 2^OUT_WIDTH-1, output 2^OUT_WIDTH-1 and set m00_axis_tuser=1 on that result; m00_axis_tuser SHALL be 0 otherwise.
REQ-012 SHALL pipeline as stage 1 (lane squares registered), stage 2 (lane sum registered, plus accumulate in ACCUM=1), and output register; latency from input handshake to m00_axis_tvalid SHALL be 3 cycles with no stall.
REQ-013 SHALL advance all stages together on enable = !m00_axis_tvalid || m00_axis_tready, and SHALL drive s00_axis_tready = enable combinationally.
REQ-014 SHALL hold m00_axis_tdata, m00_axis_tlast and m00_axis_tuser stable while m00_axis_tvalid=1 and m00_axis_tready=0.
REQ-015 SHALL propagate bubbles: a stage whose source carried no valid beat SHALL carry valid=0, with no output beat generated from it.
REQ-016 SHALL, in ACCUM=0, pass s00_axis_tlast through aligned with its own result.
REQ-017 SHALL, in ACCUM=1, accumulate lane sums in a register of OUT_WIDTH+1 bits that saturates, with a sticky overflow bit per packet. On the tlast beat it SHALL emit accumulator plus current sum with m00_axis_tlast=1, then restart from 0 for the next beat. Non-tlast beats SHALL produce no output.
REQ-018 SHALL, in ACCUM=1, when a tlast beat immediately follows a packet's emit, start the new packet from 0 with no carry-over from the previous packet.
REQ-019 SHALL drive m00_axis_tstrb all ones whenever m00_axis_tvalid=1.
REQ-020 SHALL treat the input lane value -2^(LANE_WIDTH-1) correctly; its square is 2^(2*LANE_WIDTH-2).

Reset
REQ-021 SHALL, while s00_axis_areset=1, immediately force m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser and m00_axis_tdata to 0, m00_axis_tstrb to 0, all stage valids to 0, and the accumulator and overflow bit to 0.
REQ-022 SHALL, on reset asserted mid-packet or mid-stall, discard all in-flight beats and the partial accumulation; the first beat after reset starts a new packet.

Structure
REQ-023 SHALL place a function computing the sum width, and the saturate-to-OUT_WIDTH helper, in shared package lane_power_pkg.
REQ-024 SHALL place the per-lane signed square in a pipeline register in sub-module lane_square, instantiated LANES times via generate.

Verification
REQ-025 Bench SHALL cover, with defaults and ACCUM=0: input 0x0003_FFFC (lanes +3 and -4) -> m00_axis_tdata=25 three cycles later, m00_axis_tuser=0.
REQ-026 Bench SHALL cover, with defaults and ACCUM=0: input 0x8000_8000 -> 0x8000_0000, m00_axis_tuser=0. Then with OUT_WIDTH=24, the same input -> 0xFFFFFF, m00_axis_tuser=1.
REQ-027 Bench SHALL cover backpressure: stream 8 beats with m00_axis_tready toggling at random -> exactly 8 outputs, in order, each held stable until accepted, with none lost or duplicated.
REQ-028 Bench SHALL cover ACCUM=1 with packets of 4 beats of lanes (1,1), followed by a 1-beat packet of (2,0) -> two outputs, 8 with tlast=1, then 4 with tlast=1.
REQ-029 Bench SHALL cover reset asserted after 2 beats of an ACCUM=1 packet, then a 1-beat packet of (3,0) -> single output of 9, with m00_axis_tvalid low during reset.
